dec4to2_rx: RTL

- Receive-side counterpart of the 4-to-2 priority encoder: takes the encoder's 2-bit code Y and active-low error flag _IN_ERR, and regenerates the one-hot 4-bit D.
- Codes enter through a valid/ready handshake and are buffered in a small FIFO. Decoded words leave through a second valid/ready handshake.
- Error words are counted.
- Sits between the encoder (or a link carrying its outputs) and downstream consumers of one-hot D.

---
 rtl/dec4to2_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/dec4to2_rx.sv
// Receive-side decoder for the 4-to-2 priority encoder: buffers {Y, _IN_ERR} codes in a
// small FIFO and emits one-hot D words. Optional sticky error flag: DEC4TO2_RX_STICKY_ERR_EN.
module dec4to2_rx #(
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           Y,
    input  logic                 _IN_ERR,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           D,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef DEC4TO2_RX_STICKY_ERR_EN
    ,
    output logic                 err_sticky,
    input  logic                 err_clr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Each entry is {err, d}; error words carry d = 0 regardless of Y.
    logic [4:0]           mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 push, pop, err_push;
    logic [4:0]           entry, head;

    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        err_push  = push & ~_IN_ERR;
        entry     = {~_IN_ERR, (_IN_ERR ? (4'b0001 << Y) : 4'b0000)};
        head      = out_valid ? mem_q[rd_ptr_q] : 5'b0;
        D         = head[3:0];
        out_err   = head[4];
        err_cnt   = err_cnt_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        err_cnt_d = err_cnt_q;
        if (err_push && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
`ifdef DEC4TO2_RX_STICKY_ERR_EN
        if (err_clr) begin
            err_cnt_d = err_push ? ERR_CNT_W'(1) : '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

`ifdef DEC4TO2_RX_STICKY_ERR_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (err_push) begin
            err_sticky_d = 1'b1;
        end
        err_sticky = err_sticky_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end
`endif

endmodule
